// File: rtl/tiny32_intc.sv
// Eight-source interrupt controller for the tiny32 core: synchronises requests, latches them
// as edge/level pending bits, masks them and drives the core's registered interrupt lines.
module tiny32_intc #(
   parameter int SOURCES     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic [SOURCES-1:0] irq_in,
   input  logic               sel,
   input  logic [2:0]         address,
   input  logic               nrd,
   input  logic [3:0]         nwr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic [7:0]         interrupt
);

   localparam logic [7:0] IMPL = 8'((16'd1 << SOURCES) - 16'd1);

   localparam logic [2:0] A_PENDING  = 3'd0;
   localparam logic [2:0] A_ENABLE   = 3'd1;
   localparam logic [2:0] A_MODE     = 3'd2;
   localparam logic [2:0] A_POLARITY = 3'd3;
   localparam logic [2:0] A_STATUS   = 3'd4;
   localparam logic [2:0] A_SWSET    = 3'd5;
   localparam logic [2:0] A_RAW      = 3'd6;
   localparam logic [2:0] A_CTRL     = 3'd7;

   logic [7:0] irq_ext;
   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] sync_d [SYNC_STAGES];
   logic [7:0] pending_q, pending_d;
   logic [7:0] enable_q, enable_d;
   logic [7:0] mode_q, mode_d;
   logic [7:0] polarity_q, polarity_d;
   logic       gie_q, gie_d;
   logic [7:0] s_prev_q, s_prev_d;
   logic [7:0] interrupt_q, interrupt_d;

   logic [7:0] raw;
   logic [7:0] s;
   logic [7:0] set_hw;
   logic       wr_en;
   logic [7:0] wbyte;
   logic [7:0] w1c;
   logic [7:0] swset;
   logic [7:0] rd_byte;
   logic       unused_bits;

   assign unused_bits = ^{wdata[31:8], nwr[3:1]};

   always_comb begin
      irq_ext                = '0;
      irq_ext[SOURCES-1:0]   = irq_in;
   end

   always_comb begin
      sync_d[0] = irq_ext & IMPL;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign raw    = sync_q[SYNC_STAGES-1];
   assign s      = (raw ^ polarity_q) & IMPL;
   assign set_hw = (mode_q & s & ~s_prev_q) | (~mode_q & s);

   assign wr_en = sel & ~nwr[0];
   assign wbyte = wdata[7:0] & IMPL;
   assign w1c   = (wr_en && address == A_PENDING) ? wbyte : 8'h00;
   assign swset = (wr_en && address == A_SWSET)   ? wbyte : 8'h00;

   always_comb begin
      // A set on the same clock as a W1C wins, so the clear is applied first.
      pending_d   = ((pending_q & ~w1c) | set_hw | swset) & IMPL;
      enable_d    = enable_q;
      mode_d      = mode_q;
      polarity_d  = polarity_q;
      gie_d       = gie_q;
      s_prev_d    = s;
      interrupt_d = {8{gie_q}} & pending_q & enable_q & IMPL;
      if (wr_en) begin
         case (address)
            A_ENABLE:   enable_d   = wbyte;
            A_MODE:     mode_d     = wbyte;
            A_POLARITY: polarity_d = wbyte;
            A_CTRL:     gie_d      = wdata[0];
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         pending_q   <= '0;
         enable_q    <= '0;
         mode_q      <= '0;
         polarity_q  <= '0;
         gie_q       <= 1'b0;
         s_prev_q    <= '0;
         interrupt_q <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         pending_q   <= pending_d;
         enable_q    <= enable_d;
         mode_q      <= mode_d;
         polarity_q  <= polarity_d;
         gie_q       <= gie_d;
         s_prev_q    <= s_prev_d;
         interrupt_q <= interrupt_d;
      end
   end

   always_comb begin
      rd_byte = 8'h00;
      case (address)
         A_PENDING:  rd_byte = pending_q;
         A_ENABLE:   rd_byte = enable_q;
         A_MODE:     rd_byte = mode_q;
         A_POLARITY: rd_byte = polarity_q;
         A_STATUS:   rd_byte = pending_q & enable_q;
         A_SWSET:    rd_byte = 8'h00;
         A_RAW:      rd_byte = raw;
         A_CTRL:     rd_byte = {7'b0, gie_q};
         default:    rd_byte = 8'h00;
      endcase
   end

   assign rdata     = (sel && !nrd) ? {24'b0, rd_byte} : 32'h0;
   assign interrupt = interrupt_q;

endmodule

// File: tb/tb_tiny32_intc.sv
// Bench for tiny32_intc: register table, directed corner sequences, then random traffic
// compared against a rule-level reference model.
module tb_tiny32_intc;

   localparam int SYNC = 2;

   logic        clk;
   logic        nreset;
   logic [7:0]  irq;
   logic        sel;
   logic [2:0]  addr;
   logic        nrd;
   logic [3:0]  nwr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  interrupt;

   int n_cmp = 0;
   int n_bad = 0;

   tiny32_intc #(.SOURCES(8), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .nreset(nreset), .irq_in(irq), .sel(sel), .address(addr),
      .nrd(nrd), .nwr(nwr), .wdata(wdata), .rdata(rdata), .interrupt(interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   // reference model: per-source rules applied once per clock
   typedef struct packed {
      logic [7:0] pend;
      logic [7:0] en;
      logic [7:0] mode;
      logic [7:0] pol;
      logic [7:0] sprev;
      logic [7:0] int_o;
      logic       gie;
   } mstate_t;

   mstate_t    m;
   logic [7:0] hist [SYNC];

   function automatic mstate_t mstep(mstate_t c, logic [7:0] rw, logic w, logic [2:0] a,
                                     logic [7:0] d);
      mstate_t n;
      logic    sv, set;
      n = c;
      n.int_o = c.gie ? (c.pend & c.en) : 8'h00;
      for (int i = 0; i < 8; i++) begin
         sv = rw[i] ^ c.pol[i];
         if (c.mode[i]) set = sv && !c.sprev[i];
         else           set = sv;
         if (w && a == 3'd5 && d[i]) set = 1'b1;
         if (set)                              n.pend[i] = 1'b1;
         else if (w && a == 3'd0 && d[i])      n.pend[i] = 1'b0;
         n.sprev[i] = sv;
      end
      if (w) begin
         case (a)
            3'd1:    n.en   = d;
            3'd2:    n.mode = d;
            3'd3:    n.pol  = d;
            3'd7:    n.gie  = d[0];
            default: ;
         endcase
      end
      return n;
   endfunction

   function automatic logic [7:0] mread(logic [2:0] a);
      case (a)
         3'd0:    return m.pend;
         3'd1:    return m.en;
         3'd2:    return m.mode;
         3'd3:    return m.pol;
         3'd4:    return m.pend & m.en;
         3'd6:    return hist[SYNC-1];
         3'd7:    return {7'b0, m.gie};
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m <= '0;
         for (int i = 0; i < SYNC; i++) hist[i] <= 8'h00;
      end else begin
         m <= mstep(m, hist[SYNC-1], sel && !nwr[0], addr, wdata[7:0]);
         hist[0] <= irq;
         for (int i = 1; i < SYNC; i++) hist[i] <= hist[i-1];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] n = 4'b1110);
      @(negedge clk);
      sel = 1'b1; addr = a; nwr = n; wdata = d;
      @(negedge clk);
      sel = 1'b0; nwr = 4'hF; wdata = '0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
      sel = 1'b1; nrd = 1'b0; addr = a;
      #1;
      chk(name, rdata, {24'b0, exp});
      sel = 1'b0; nrd = 1'b1;
   endtask

   typedef struct {
      logic [2:0]  waddr;
      logic [3:0]  wn;
      logic [31:0] wd;
      logic [2:0]  raddr;
      logic [7:0]  exp;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{3'd1, 4'b1110, 32'h0000_00A5, 3'd1, 8'hA5};
      tbl[1] = '{3'd2, 4'b1110, 32'h0000_00FF, 3'd2, 8'hFF};
      tbl[2] = '{3'd7, 4'b1110, 32'hFFFF_FFFF, 3'd7, 8'h01};
      tbl[3] = '{3'd5, 4'b1110, 32'h0000_0080, 3'd0, 8'h80};
      tbl[4] = '{3'd6, 4'b1110, 32'h0000_00FF, 3'd6, 8'h00};
      tbl[5] = '{3'd4, 4'b1110, 32'h0000_00FF, 3'd4, 8'h80};
      tbl[6] = '{3'd0, 4'b1110, 32'h0000_0080, 3'd0, 8'h00};
      tbl[7] = '{3'd1, 4'b1110, 32'hFFFF_FF00, 3'd1, 8'h00};
      tbl[8] = '{3'd1, 4'b0001, 32'h0000_00FF, 3'd1, 8'h00};
      tbl[9] = '{3'd5, 4'b1110, 32'h0000_00FF, 3'd5, 8'h00};

      nreset = 1'b0; irq = '0; sel = 1'b0; addr = '0; nrd = 1'b1; nwr = 4'hF; wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_interrupt", {24'b0, interrupt}, 32'h0);
      chk("reset_rdata_idle", rdata, 32'h0);
      nreset = 1'b1;
      @(negedge clk);
      rd_chk("reset_pending", 3'd0, 8'h00);

      // register table
      for (int i = 0; i < 10; i++) begin
         wr(tbl[i].waddr, tbl[i].wd, tbl[i].wn);
         rd_chk($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
      end
      wr(3'd0, 32'hFF); wr(3'd7, 32'h0); wr(3'd2, 32'h0);

      // edge capture of a one-clock pulse
      wr(3'd1, 32'h08); wr(3'd2, 32'h08); wr(3'd7, 32'h01);
      irq = 8'h08;
      @(negedge clk); irq = 8'h00;
      @(negedge clk);
      @(negedge clk); chk("edge_int_e3", {24'b0, interrupt}, 32'h00);
      @(negedge clk); chk("edge_int_e4", {24'b0, interrupt}, 32'h08);
      repeat (3) @(negedge clk);
      chk("edge_int_holds", {24'b0, interrupt}, 32'h08);
      wr(3'd0, 32'h08);
      chk("edge_w1c_commit", {24'b0, interrupt}, 32'h08);
      @(negedge clk); chk("edge_w1c_drop", {24'b0, interrupt}, 32'h00);

      // level mode, W1C collides with an active source
      wr(3'd2, 32'h00); wr(3'd1, 32'h02);
      irq = 8'h02;
      repeat (4) @(negedge clk);
      rd_chk("level_pend", 3'd0, 8'h02);
      wr(3'd0, 32'h02);
      rd_chk("level_w1c_active", 3'd0, 8'h02);
      irq = 8'h00;
      repeat (3) @(negedge clk);
      rd_chk("level_latched", 3'd0, 8'h02);
      wr(3'd0, 32'h02);
      rd_chk("level_w1c_idle", 3'd0, 8'h00);
      wr(3'd5, 32'h80);
      rd_chk("swset_80", 3'd0, 8'h80);
      wr(3'd0, 32'h80);

      // masking and readback
      wr(3'd5, 32'h05); wr(3'd1, 32'h04); wr(3'd7, 32'h01);
      rd_chk("mask_status", 3'd4, 8'h04);
      @(negedge clk); chk("mask_int", {24'b0, interrupt}, 32'h04);
      wr(3'd7, 32'h00);
      @(negedge clk); chk("gie_off_int", {24'b0, interrupt}, 32'h00);
      rd_chk("gie_off_pend", 3'd0, 8'h05);
      wr(3'd0, 32'h05);

      // polarity and byte lanes
      wr(3'd2, 32'h01);
      wr(3'd3, 32'h01);
      rd_chk("pol_write_commit", 3'd0, 8'h00);
      @(negedge clk);
      rd_chk("pol_write_edge", 3'd0, 8'h01);
      wr(3'd0, 32'h01);
      rd_chk("pol_cleared", 3'd0, 8'h00);
      irq = 8'h01;
      repeat (4) @(negedge clk);
      rd_chk("pol_raw", 3'd6, 8'h01);
      rd_chk("pol_rise_ignored", 3'd0, 8'h00);
      irq = 8'h00;
      repeat (4) @(negedge clk);
      rd_chk("pol_fall_sets", 3'd0, 8'h01);
      wr(3'd0, 32'h01);
      wr(3'd3, 32'hFFFF_FF00, 4'b1110);
      rd_chk("lane_zero_write", 3'd3, 8'h00);
      wr(3'd3, 32'h0000_00FF, 4'b0001);
      rd_chk("lane_ignored", 3'd3, 8'h00);
      rd_chk("lane_pend", 3'd0, 8'h00);

      // reset mid-operation
      wr(3'd2, 32'h00); wr(3'd1, 32'hFF); wr(3'd5, 32'hFF); wr(3'd7, 32'h01);
      @(negedge clk); chk("pre_reset_int", {24'b0, interrupt}, 32'hFF);
      #2 nreset = 1'b0;
      #1 chk("async_reset_int", {24'b0, interrupt}, 32'h00);
      @(negedge clk); nreset = 1'b1;
      for (int a = 0; a < 8; a++) rd_chk($sformatf("post_reset_r%0d", a), 3'(a), 8'h00);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         irq   = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         sel   = ($urandom_range(0, 3) != 0);
         nrd   = $urandom_range(0, 1) == 1;
         addr  = 3'($urandom);
         wdata = $urandom;
         nwr   = {3'($urandom), ($urandom_range(0, 5) != 0)};
         #1;
         chk("rand_int", {24'b0, interrupt}, {24'b0, m.int_o});
         chk("rand_rdata", rdata, (sel && !nrd) ? {24'b0, mread(addr)} : 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
